// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the CPU datapath.
// Latency: none, wires only.
// Backpressure: none; the datapath follows the controller every cycle.
interface mc_ctrl_if #(
  parameter int RET_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic [1:0]       regdst;
  logic             alusrc;
  logic [1:0]       memtoreg;
  logic             regwe;
  logic             memwe;
  logic             branch;
  logic [1:0]       jump;
  logic [1:0]       extop;
  logic [1:0]       aluop;
  logic             pcwe;
  logic             irwe;
  logic [2:0]       state;
  logic             retire;
  logic [RET_W-1:0] retired;
  logic             illegal;

  // Controller side.
  modport master (
    input  instr, zero,
    output regdst, alusrc, memtoreg, regwe, memwe, branch, jump, extop, aluop,
           pcwe, irwe, state, retire, retired, illegal
  );

  // Datapath side.
  modport slave (
    output instr, zero,
    input  regdst, alusrc, memtoreg, regwe, memwe, branch, jump, extop, aluop,
           pcwe, irwe, state, retire, retired, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: decodes IR and steps FETCH/DECODE/EXE/MEM/WB.
// Latency: 2-5 cycles per instruction depending on class; selects are combinational.
// Backpressure: none; the datapath is assumed to complete every step in one cycle.
module mc_ctrl #(
  parameter int RET_W = 32
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_ILL
  } kind_t;

  state_t           state_q;
  logic [RET_W-1:0] retired_q;
  kind_t            kind;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             active;

  // Branch resolution lives in the datapath next-PC logic, so the zero flag
  // and the register/immediate fields are not needed here.
  logic unused_bits;
  assign unused_bits = ^{bus.zero, bus.instr[25:6]};

  assign op    = bus.instr[31:26];
  assign funct = bus.instr[5:0];

  // Selects only drive the datapath once IR holds the instruction (DECODE onward).
  assign active = rst && (state_q == S_DECODE || state_q == S_EXE ||
                          state_q == S_MEM    || state_q == S_WB);

  // Classify the instruction in IR.
  always_comb begin
    kind = K_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: kind = K_ADDU;
          6'b100011: kind = K_SUBU;
          6'b001000: kind = K_JR;
          default:   kind = K_ILL;
        endcase
      end
      6'b001101: kind = K_ORI;
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: kind = K_BEQ;
      6'b001111: kind = K_LUI;
      6'b000010: kind = K_J;
      6'b000011: kind = K_JAL;
      default:   kind = K_ILL;
    endcase
  end

  // Datapath selects, held for the whole instruction and zero in FETCH/reset.
  always_comb begin
    bus.regdst   = 2'b00;
    bus.alusrc   = 1'b0;
    bus.memtoreg = 2'b00;
    bus.branch   = 1'b0;
    bus.jump     = 2'b00;
    bus.extop    = 2'b00;
    bus.aluop    = 2'b00;
    if (active) begin
      case (kind)
        K_ADDU: begin
          bus.regdst = 2'b01;
          bus.aluop  = 2'b00;
        end
        K_SUBU: begin
          bus.regdst = 2'b01;
          bus.aluop  = 2'b01;
        end
        K_ORI: begin
          bus.alusrc = 1'b1;
          bus.extop  = 2'b00;
          bus.aluop  = 2'b10;
        end
        K_LUI: begin
          bus.alusrc = 1'b1;
          bus.extop  = 2'b10;
          bus.aluop  = 2'b00;
        end
        K_LW: begin
          bus.alusrc   = 1'b1;
          bus.extop    = 2'b01;
          bus.memtoreg = 2'b01;
        end
        K_SW: begin
          bus.alusrc = 1'b1;
          bus.extop  = 2'b01;
        end
        K_BEQ: begin
          bus.aluop  = 2'b01;
          bus.branch = 1'b1;
        end
        K_J: bus.jump = 2'b01;
        K_JAL: begin
          bus.jump     = 2'b01;
          bus.regdst   = 2'b10;
          bus.memtoreg = 2'b10;
        end
        K_JR:    bus.jump = 2'b10;
        default: ;
      endcase
    end
  end

  // Write enables per state; decoded from the live state because IR is only
  // valid from DECODE, so DECODE-cycle enables cannot be precomputed a cycle early.
  always_comb begin
    bus.irwe    = 1'b0;
    bus.pcwe    = 1'b0;
    bus.regwe   = 1'b0;
    bus.memwe   = 1'b0;
    bus.illegal = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: bus.irwe = 1'b1;
        S_DECODE: begin
          if (kind == K_J || kind == K_JAL || kind == K_JR || kind == K_ILL)
            bus.pcwe = 1'b1;
          if (kind == K_JAL) bus.regwe = 1'b1;
          if (kind == K_ILL) bus.illegal = 1'b1;
        end
        S_EXE: begin
          if (kind == K_BEQ) bus.pcwe = 1'b1;
        end
        S_MEM: begin
          if (kind == K_SW) begin
            bus.memwe = 1'b1;
            bus.pcwe  = 1'b1;
          end
        end
        S_WB: begin
          bus.regwe = 1'b1;
          bus.pcwe  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A skipped illegal instruction moves the PC but is not counted as retired.
  assign bus.retire  = bus.pcwe && !bus.illegal;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

  // Sequencer and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      if (bus.retire) retired_q <= retired_q + {{(RET_W-1){1'b0}}, 1'b1};
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (kind == K_J || kind == K_JAL || kind == K_JR || kind == K_ILL)
            state_q <= S_FETCH;
          else
            state_q <= S_EXE;
        end
        S_EXE: begin
          if (kind == K_BEQ)                     state_q <= S_FETCH;
          else if (kind == K_LW || kind == K_SW) state_q <= S_MEM;
          else                                   state_q <= S_WB;
        end
        S_MEM: begin
          if (kind == K_LW) state_q <= S_WB;
          else              state_q <= S_FETCH;
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
